// File: rtl/seven_seg_axi_updater_if.sv
// AXI4-Lite write-only channel bundle between the display updater
// (master) and the seven-segment display IP (slave).
interface seven_seg_axi_updater_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awprot, awvalid,
        output wdata, wstrb, wvalid,
        output bready,
        input  awready, wready,
        input  bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        input  wdata, wstrb, wvalid,
        input  bready,
        output awready, wready,
        output bresp, bvalid
    );
endinterface

// File: rtl/seven_seg_axi_updater.sv
// Seven-segment display updater: turns display snapshots into the
// minimal ordered set of AXI4-Lite register writes.
module seven_seg_axi_updater #(
    parameter int unsigned C_NUM_DIGITS     = 8,
    parameter int unsigned C_BASE_ADDR      = 32'h43C00000,
    parameter int unsigned C_ADDR_WIDTH     = 32,
    parameter bit          C_SKIP_UNCHANGED = 1'b1
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_aresetn,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [31:0]               upd_ctrl,
    input  logic [C_NUM_DIGITS*8-1:0] upd_digits,
    output logic                      done,
    output logic                      err,
    seven_seg_axi_updater_if.master   m_axi
);
    localparam int unsigned NW    = (C_NUM_DIGITS + 3) / 4;
    localparam int unsigned IW    = $clog2(NW + 2);
    localparam int unsigned DEPTH = 1 << IW;
    localparam int unsigned PW    = NW * 32;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WRITE,
        RESP,
        FINISH
    } state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DEPTH-1:0][31:0]  snap_q, snap_d, words;
    logic [DEPTH-1:0]        dirty_q, dirty_d, dirty_new;
    logic [NW:0][31:0]       shadow_q, shadow_d;
    logic [NW:0]             shv_q, shv_d;
    logic [PW-1:0]           digits_pad;
    logic [C_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    rdy_q, rdy_d;
    logic                    accept, aw_hs, w_hs, b_hs;

    // Missing digit positions in the last word pack as zero bytes.
    assign digits_pad = PW'(upd_digits);

    assign words[0] = upd_ctrl;
    for (genvar g = 1; g <= NW; g++) begin : g_word
        assign words[g] = digits_pad[(g-1)*32 +: 32];
    end
    assign words[DEPTH-1:NW+1] = '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_dirty
        if (g <= NW) begin : g_live
            assign dirty_new[g] = !C_SKIP_UNCHANGED || !shv_q[g] ||
                                  (shadow_q[g] != words[g]);
        end else begin : g_pad
            assign dirty_new[g] = 1'b0;
        end
    end

    assign accept = upd_valid && rdy_q;
    assign aw_hs  = awvalid_q && m_axi.awready;
    assign w_hs   = wvalid_q && m_axi.wready;
    assign b_hs   = bready_q && m_axi.bvalid;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        dirty_d   = dirty_q;
        shadow_d  = shadow_q;
        shv_d     = shv_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        done_d    = 1'b0;
        err_d     = err_q;
        rdy_d     = rdy_q;
        unique case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (accept) begin
                    snap_d  = words;
                    dirty_d = dirty_new;
                    idx_d   = '0;
                    rdy_d   = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (idx_q > IW'(NW)) begin
                    done_d  = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = FINISH;
                end else if (dirty_q[idx_q]) begin
                    awaddr_d  = C_ADDR_WIDTH'(C_BASE_ADDR) +
                                C_ADDR_WIDTH'({idx_q, 2'b00});
                    wdata_d   = snap_q[idx_q];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WRITE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            WRITE: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs) wvalid_d = 1'b0;
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    for (int k = 0; k < NW + 1; k++) begin
                        if (idx_q == IW'(k)) begin
                            shadow_d[k] = snap_q[idx_q];
                            shv_d[k]    = 1'b1;
                        end
                    end
                    // A failed write is recorded but never retried.
                    if (m_axi.bresp != 2'b00) err_d = 1'b1;
                    idx_d   = idx_q + IW'(1);
                    state_d = SCAN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            snap_q    <= '0;
            dirty_q   <= '0;
            shadow_q  <= '0;
            shv_q     <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            dirty_q   <= dirty_d;
            shadow_q  <= shadow_d;
            shv_q     <= shv_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
        end
    end

    assign upd_ready     = rdy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
endmodule

// File: tb/tb_seven_seg_axi_updater.sv
// Randomized bench for seven_seg_axi_updater: behavioural slave plus a
// shadow-register reference model of the expected write sequence.
module tb_seven_seg_axi_updater;
    localparam int ND = 15;
    localparam int NW = (ND + 3) / 4;
    localparam logic [31:0] BASE = 32'h43C00000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            upd_valid = 1'b0;
    logic            upd_ready;
    logic [31:0]     upd_ctrl = '0;
    logic [ND*8-1:0] upd_digits = '0;
    logic            done;
    logic            err;

    seven_seg_axi_updater_if #(.ADDR_WIDTH(32)) axi ();

    seven_seg_axi_updater #(
        .C_NUM_DIGITS    (ND),
        .C_BASE_ADDR     (BASE),
        .C_ADDR_WIDTH    (32),
        .C_SKIP_UNCHANGED(1'b1)
    ) dut (
        .m_axi_aclk   (clk),
        .m_axi_aresetn(rst_n),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_ctrl     (upd_ctrl),
        .upd_digits   (upd_digits),
        .done         (done),
        .err          (err),
        .m_axi        (axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave knobs and observations.
    int aw_dly = 0, w_dly = 0, b_dly = 0;
    int err_wr = -1;
    int wr_num = 0, nb = 0, done_cnt = 0, viol = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit aw_got, w_got, aw_pend, w_pend, b_pend;
    bit prev_aw_wait, prev_w_wait;
    logic [31:0] prev_awaddr, prev_wdata;
    logic [31:0] obs_addr[$], obs_data[$];

    task automatic slave_clear();
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        aw_got = 0; w_got = 0; aw_pend = 0; w_pend = 0; b_pend = 0;
        prev_aw_wait = 0; prev_w_wait = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    endtask

    // Readies are decided on the falling edge; a handshake predicted here
    // completes on the following rising edge.
    initial begin
        slave_clear();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slave_clear();
                continue;
            end
            if (done) done_cnt++;
            if (aw_pend) begin aw_got = 1; aw_cnt = 0; end
            if (w_pend) begin w_got = 1; w_cnt = 0; end
            if (b_pend) begin
                axi.bvalid = 1'b0;
                aw_got = 0; w_got = 0; b_cnt = 0;
                wr_num++; nb++;
            end
            if (prev_aw_wait && (!axi.awvalid || axi.awaddr !== prev_awaddr)) viol++;
            if (prev_w_wait && (!axi.wvalid || axi.wdata !== prev_wdata)) viol++;
            if (aw_got && axi.awvalid) viol++;
            if (w_got && axi.wvalid) viol++;
            if (axi.awvalid) aw_cnt++;
            if (axi.wvalid) w_cnt++;
            axi.awready = (aw_dly == 0) || (axi.awvalid && aw_cnt > aw_dly);
            axi.wready  = (w_dly == 0) || (axi.wvalid && w_cnt > w_dly);
            aw_pend = axi.awvalid && axi.awready;
            w_pend  = axi.wvalid && axi.wready;
            if (aw_pend) begin
                obs_addr.push_back(axi.awaddr);
                if (axi.awprot !== 3'b000) viol++;
            end
            if (w_pend) begin
                obs_data.push_back(axi.wdata);
                if (axi.wstrb !== 4'hF) viol++;
            end
            prev_aw_wait = axi.awvalid && !axi.awready;
            prev_w_wait  = axi.wvalid && !axi.wready;
            prev_awaddr  = axi.awaddr;
            prev_wdata   = axi.wdata;
            if (aw_got && w_got && !axi.bvalid) begin
                b_cnt++;
                if (b_cnt > b_dly) begin
                    axi.bvalid = 1'b1;
                    axi.bresp = (wr_num == err_wr) ? 2'b10 : 2'b00;
                end
            end
            b_pend = axi.bvalid && axi.bready;
        end
    end

    // Reference model: display register shadow and expected write list.
    logic [31:0] m_shadow[NW+1];
    bit          m_valid[NW+1];
    bit          m_err = 0;
    logic [31:0] exp_addr[$], exp_data[$];

    function automatic void model_snapshot(logic [31:0] ctrl, logic [ND*8-1:0] dig);
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i <= NW; i++) begin
            w = '0;
            if (i == 0) w = ctrl;
            else begin
                for (int b = 0; b < 4; b++) begin
                    int d;
                    d = 4 * (i - 1) + b;
                    if (d < ND) w[8*b +: 8] = dig[8*d +: 8];
                end
            end
            if (!m_valid[i] || m_shadow[i] !== w) begin
                exp_addr.push_back(BASE + 32'(4 * i));
                exp_data.push_back(w);
                m_shadow[i] = w;
                m_valid[i] = 1;
            end
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_snap(string tag, logic [31:0] ctrl, logic [ND*8-1:0] dig);
        int budget;
        int nb0;
        model_snapshot(ctrl, dig);
        if (err_wr >= wr_num && err_wr < wr_num + exp_addr.size()) m_err = 1;
        obs_addr.delete();
        obs_data.delete();
        nb0 = nb;
        done_cnt = 0;
        tick();
        check_eq({tag, ".rdy"}, upd_ready, 1);
        upd_ctrl = ctrl;
        upd_digits = dig;
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        check_eq({tag, ".busy"}, upd_ready, 0);
        budget = 0;
        while (done_cnt == 0 && budget < 400) begin
            tick();
            budget++;
        end
        repeat (5) tick();
        check_eq({tag, ".done"}, done_cnt, 1);
        check_eq({tag, ".naw"}, obs_addr.size(), exp_addr.size());
        check_eq({tag, ".nw"}, obs_data.size(), exp_data.size());
        check_eq({tag, ".nb"}, nb - nb0, exp_addr.size());
        for (int k = 0; k < exp_addr.size(); k++) begin
            if (k < obs_addr.size()) check_eq({tag, ".addr"}, obs_addr[k], exp_addr[k]);
            if (k < obs_data.size()) check_eq({tag, ".data"}, obs_data[k], exp_data[k]);
        end
        check_eq({tag, ".err"}, err, m_err);
        check_eq({tag, ".idle"}, upd_ready, 1);
        check_eq({tag, ".proto"}, viol, 0);
    endtask

    logic [7:0] tp_dig[ND] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06,
                               8'h05, 8'h0C, 8'h0B, 8'h0A, 8'h09, 8'h80, 8'h8F,
                               8'h8E};
    logic [31:0] tp_word[NW+1] = '{32'h3, 32'h01020304, 32'h05060708,
                                   32'h090A0B0C, 32'h008E8F80};

    initial begin
        logic [ND*8-1:0] dig;
        logic [31:0]     ctrl;
        int              budget;

        #2 rst_n = 1'b0;
        #1;
        check_eq("reset.rdy", upd_ready, 1);
        check_eq("reset.awvalid", axi.awvalid, 0);
        check_eq("reset.wvalid", axi.wvalid, 0);
        check_eq("reset.bready", axi.bready, 0);
        check_eq("reset.done", done, 0);
        check_eq("reset.err", err, 0);
        check_eq("reset.awaddr", axi.awaddr, 0);
        check_eq("reset.wdata", axi.wdata, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        for (int d = 0; d < ND; d++) dig[8*d +: 8] = tp_dig[d];
        ctrl = 32'h3;
        run_snap("tp_full", ctrl, dig);
        for (int k = 0; k <= NW; k++) begin
            if (k < obs_data.size()) check_eq("tp_full.word", obs_data[k], tp_word[k]);
            if (k < obs_addr.size()) check_eq("tp_full.waddr", obs_addr[k], BASE + 32'(4 * k));
        end

        run_snap("tp_ctrl", 32'h1, dig);
        check_eq("tp_ctrl.count", obs_addr.size(), 1);
        run_snap("tp_same", 32'h1, dig);
        check_eq("tp_same.count", obs_addr.size(), 0);

        aw_dly = 3; w_dly = 0;
        dig[7:0] = 8'h85;
        run_snap("aw_slow", 32'h5, dig);
        aw_dly = 0; w_dly = 3; b_dly = 2;
        dig[63:56] = 8'h0D;
        run_snap("w_slow", 32'h6, dig);
        w_dly = 0; b_dly = 0;

        err_wr = wr_num + 1;
        for (int d = 0; d < ND; d++) dig[8*d +: 8] = 8'(d + 1);
        run_snap("bresp_err", 32'h7, dig);
        err_wr = -1;
        run_snap("err_sticky", 32'h8, dig);

        for (int t = 0; t < 16; t++) begin
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) ctrl = $urandom;
            for (int d = 0; d < ND; d++)
                if ($urandom_range(0, 9) < 3) dig[8*d +: 8] = 8'($urandom);
            run_snap("rand", ctrl, dig);
        end

        aw_dly = 20; w_dly = 0; b_dly = 0;
        tick();
        upd_ctrl = 32'hA5;
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        budget = 0;
        while (!axi.awvalid && budget < 50) begin
            tick();
            budget++;
        end
        check_eq("midrst.awvalid_seen", axi.awvalid, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst.awvalid", axi.awvalid, 0);
        check_eq("midrst.wvalid", axi.wvalid, 0);
        check_eq("midrst.bready", axi.bready, 0);
        check_eq("midrst.rdy", upd_ready, 1);
        check_eq("midrst.err", err, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        aw_dly = 0;
        m_err = 0;
        for (int i = 0; i <= NW; i++) m_valid[i] = 0;
        repeat (2) tick();
        run_snap("post_rst", ctrl, dig);
        check_eq("post_rst.count", obs_addr.size(), NW + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
